// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N phase-accumulator baud generator with oversample, baud and mid-bit ticks
module baud_gen_frac #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD = 115200,
    parameter int OSR = 16,
    parameter int ACC_W = 24,
    localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sync,
    input  logic             inc_wr,
    input  logic [ACC_W-1:0] inc_din,
    output logic [ACC_W-1:0] inc_q,
    output logic             os_tick,
    output logic             baud_tick,
    output logic             mid_tick,
    output logic [PH_W-1:0]  os_phase
);
    localparam logic [63:0] INC_64 =
        (64'(BAUD) * 64'(OSR) * (64'd1 << ACC_W) + 64'(CLK_HZ) / 64'd2) / 64'(CLK_HZ);
    localparam logic [ACC_W-1:0] INC_RST = INC_64[ACC_W-1:0];
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0] PH_MID = PH_W'(OSR / 2);

    if (OSR < 4 || OSR > 256 || (OSR % 2) != 0 || ACC_W < 8 || ACC_W > 32) begin : g_bad_param
        $error("baud_gen_frac: illegal OSR or ACC_W");
    end
    if (INC_64 == 64'd0 || INC_64 >= (64'd1 << ACC_W)) begin : g_bad_inc
        $error("baud_gen_frac: reset increment out of range");
    end

    logic [ACC_W-1:0] acc, inc;
    logic [ACC_W:0]   sum;
    logic [PH_W-1:0]  os_cnt, os_nxt;
    logic             carry;

    always_comb begin
        sum = {1'b0, acc} + {1'b0, inc};
        carry = sum[ACC_W];
        os_nxt = (os_cnt == PH_LAST) ? '0 : os_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            os_cnt <= '0;
            os_tick <= 1'b0;
            baud_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else if (!enable || sync) begin
            acc <= '0;
            os_cnt <= '0;
            os_tick <= 1'b0;
            baud_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            os_tick <= carry;
            baud_tick <= carry && os_nxt == '0;
            mid_tick <= carry && os_nxt == PH_MID;
            if (carry) os_cnt <= os_nxt;
        end
    end

    // a zero write is dropped so the tick stream can never stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inc <= INC_RST;
        else if (inc_wr && inc_din != '0) inc <= inc_din;
    end

    assign inc_q = inc;
    assign os_phase = os_cnt;
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: directed self-checking bench for baud_gen_frac at default parameters
module tb_baud_gen_frac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        sync = 1'b0;
    logic        inc_wr = 1'b0;
    logic [23:0] inc_din = '0;
    logic [23:0] inc_q;
    logic        os_tick, baud_tick, mid_tick;
    logic [3:0]  os_phase;

    int total = 0;
    int bad = 0;

    baud_gen_frac dut (
        .clk(clk), .rst(rst), .enable(enable), .sync(sync),
        .inc_wr(inc_wr), .inc_din(inc_din), .inc_q(inc_q),
        .os_tick(os_tick), .baud_tick(baud_tick), .mid_tick(mid_tick),
        .os_phase(os_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ticks(input string tag, input logic o, input logic b, input logic m, input logic [3:0] ph);
        chk(tag, 64'({os_tick, baud_tick, mid_tick, os_phase}), 64'({o, b, m, ph}));
    endtask

    initial begin
        int n_os, n_baud, n_mid, n_align, last, iv_min, iv_max, k, n;
        logic found;
        repeat (2) step();
        chk("rst_inc", 64'(inc_q), 64'd618475);
        chk_ticks("rst_out", 1'b0, 1'b0, 1'b0, 4'd0);

        // default rate: floor(20000*618475/2^24) = 737 os ticks
        rst = 1'b0;
        n_os = 0; n_baud = 0; n_mid = 0; n_align = 0; last = -1; iv_min = 1000; iv_max = 0;
        for (int i = 1; i <= 20000; i++) begin
            step();
            n_align += int'((baud_tick || mid_tick) && !os_tick);
            n_baud += int'(baud_tick);
            n_mid += int'(mid_tick);
            if (os_tick) begin
                n_os++;
                if (last >= 0) begin
                    iv_min = (i - last < iv_min) ? i - last : iv_min;
                    iv_max = (i - last > iv_max) ? i - last : iv_max;
                end
                last = i;
            end
        end
        chk("rate_os", 64'(n_os), 64'd737);
        chk("rate_baud", 64'(n_baud), 64'd46);
        chk("rate_mid", 64'(n_mid), 64'd46);
        chk("rate_align", 64'(n_align), 64'd0);
        chk("rate_iv_min", 64'(iv_min), 64'd27);
        chk("rate_iv_max", 64'(iv_max), 64'd28);

        // exact divide: inc = 2^22 gives an os tick every 4 cycles
        inc_wr = 1'b1; inc_din = 24'd4194304; sync = 1'b1;
        step();
        inc_wr = 1'b0; sync = 1'b0;
        chk("exact_inc", 64'(inc_q), 64'd4194304);
        chk_ticks("exact_clr", 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 64; i++) begin
            step();
            chk_ticks($sformatf("exact_e%0d", i), i % 4 == 0, i == 64, i == 32, 4'((i / 4) % 16));
        end

        // fractional: inc = 3/8 of full scale, intervals 3,3,2
        inc_wr = 1'b1; inc_din = 24'd6291456; sync = 1'b1;
        step();
        inc_wr = 1'b0; sync = 1'b0;
        n_os = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            n_os += int'(os_tick);
            chk($sformatf("frac_e%0d", i), 64'(os_tick), 64'((i % 8 == 3) || (i % 8 == 6) || (i % 8 == 0)));
        end
        chk("frac_cnt", 64'(n_os), 64'd9);

        // sync mid-bit at phase 9 with the default increment restored
        inc_wr = 1'b1; inc_din = 24'd618475; sync = 1'b1;
        step();
        inc_wr = 1'b0; sync = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            found = (os_phase == 4'd9);
        end
        chk("sync_reach9", 64'(found), 64'd1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk_ticks("sync_clr", 1'b0, 1'b0, 1'b0, 4'd0);
        n_os = 0; n_mid = 0; k = 0; found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            n_os += int'(os_tick);
            if (mid_tick && k == 0) k = n_os;
            found = baud_tick;
        end
        chk("sync_baud_seen", 64'(found), 64'd1);
        chk("sync_baud_ticks", 64'(n_os), 64'd16);
        chk("sync_mid_ticks", 64'(k), 64'd8);

        // zero write is ignored and ticks continue
        inc_wr = 1'b1; inc_din = 24'd0;
        step();
        inc_wr = 1'b0;
        chk("zero_inc", 64'(inc_q), 64'd618475);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n += int'(os_tick);
        end
        chk("zero_ticks", 64'(n >= 3), 64'd1);

        // write while disabled, then re-enable behaves like a sync
        enable = 1'b0;
        step();
        inc_wr = 1'b1; inc_din = 24'd4194304;
        step();
        inc_wr = 1'b0;
        chk("dis_inc", 64'(inc_q), 64'd4194304);
        chk_ticks("dis_clr", 1'b0, 1'b0, 1'b0, 4'd0);
        enable = 1'b1;
        repeat (3) step();
        chk("dis_pre", 64'(os_tick), 64'd0);
        step();
        chk_ticks("dis_first", 1'b1, 1'b0, 1'b0, 4'd1);

        // write coinciding with reset is lost
        inc_wr = 1'b1; inc_din = 24'd123; rst = 1'b1;
        step();
        rst = 1'b0; inc_wr = 1'b0;
        chk("rstwr_inc", 64'(inc_q), 64'd618475);

        // async reset between edges while os_tick is high
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = os_tick;
        end
        chk("async_seen", 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_ticks("async_out", 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Fractional-N baud generator, successor to the integer-divide baud tick source in the UART. A phase accumulator produces an oversample tick (`OSR` × baud) with at most one clock of jitter and no long-term rate error. It also produces a 1× baud tick and a mid-bit sample strobe derived from that oversample tick. The UART RX sampler uses `os_tick` and `mid_tick`, the TX serializer uses `baud_tick`, and the divisor is reprogrammable at run time through a register write port.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: input clock frequency in Hz.
- `BAUD`, 115200: reset-default baud rate.
- `OSR`, 16: oversample ratio. Legal range is 4..256 and must be even.
- `ACC_W`, 24: accumulator and increment width. Legal range is 8..32.
- Derived constant `INC_RST` = round(BAUD·OSR·2^ACC_W / CLK_HZ), computed in 64-bit arithmetic.
  - Elaboration fails unless 0 < `INC_RST` < 2^ACC_W.
  - With the default parameters, `INC_RST` = 618475.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: when low, the generator is held idle and cleared.
- `sync` in 1: phase restart pulse. It realigns the bit boundary, for example on the RX start-bit edge.
- `inc_wr` in 1: write strobe for the increment register.
- `inc_din` in ACC_W: new increment value.
- `inc_q` out ACC_W: current increment register value.
- `os_tick` out 1: oversample tick, a one-cycle pulse.
- `baud_tick` out 1: one-cycle pulse, asserted once every `OSR` oversample ticks.
- `mid_tick` out 1: one-cycle pulse at the mid-bit oversample.
- `os_phase` out max(1,$clog2(OSR)): current oversample index, 0..OSR-1.

## Operation
Registers:
- `acc` (ACC_W bits)
- `inc` (ACC_W bits)
- `os_cnt` (width of `os_phase`)
- the three tick outputs, all registered

Reset (`rst`=1, asynchronous):
- `acc`=0, `os_cnt`=0, `inc`=INC_RST.
- `os_tick`, `baud_tick` and `mid_tick` are all 0.

Priority at each clock edge, highest first: `rst`, then `!enable`, then `sync`, then normal counting.

- **`enable`=0:**
  - `acc`←0 and `os_cnt`←0.
  - All ticks ←0.
- **`sync`=1 (with `enable`=1):** same clearing as `enable`=0. Counting resumes on the next cycle.
- **Normal counting:**
  - Form `sum` = `acc` + `inc` as an (ACC_W+1)-bit value.
  - `acc`←`sum`[ACC_W-1:0].
  - `os_tick`←`sum`[ACC_W], i.e. the carry out.
- **On a carry:**
  - `os_cnt`←(`os_cnt`==OSR-1) ? 0 : `os_cnt`+1.
  - `baud_tick`←1 if the new `os_cnt` is 0.
  - `mid_tick`←1 if the new `os_cnt` is OSR/2.
- **Without a carry:** `os_cnt` holds, and `baud_tick` and `mid_tick` go to 0.
- `baud_tick` and `mid_tick` are only ever asserted in the same cycle as `os_tick`.
- **`inc_wr`=1:**
  - `inc`←`inc_din` at the edge. The new value is used for accumulation from the following cycle onward.
  - Writes are honoured regardless of `enable` and `sync`. A write does not clear `acc` or `os_cnt`.
  - A write with `inc_din`==0 is ignored and `inc` keeps its value, so a zero write cannot stall the ticks.
  - A write in the same cycle as `rst` is lost, because reset wins.
- `inc_q` is a direct copy of the `inc` register.
- `os_phase` is a direct copy of `os_cnt`.

## Timing
- **First tick after a clear:** after the last clearing edge (`sync` or `enable` low), the first `os_tick` is high following edge n. n is the smallest integer with n·`inc` ≥ 2^ACC_W.
- **Long-term rate:** `os_tick` rate is exactly CLK_HZ·`inc`/2^ACC_W.
  - Interval between `os_tick` pulses is ⌊2^ACC_W/`inc`⌋ or ⌈2^ACC_W/`inc`⌉ cycles, no others.
- **Baud tick:** the first `baud_tick` after a clear occurs on the OSR-th `os_tick`. It is one bit period after the clear, which places the bit boundary relative to `sync`.
- **Mid tick:** the first `mid_tick` after a clear occurs on the (OSR/2)-th `os_tick`, i.e. the mid-bit sample point.
- **`inc` ≥ 2^(ACC_W-1):** `os_tick` may assert on consecutive cycles. This is legal, and `os_cnt` still advances once per tick.
- **Accumulator wrap:** `acc` wraps modulo 2^ACC_W with no saturation. The residue is kept across `inc` writes.
- **Re-enable:** deasserting and reasserting `enable` gives timing identical to a `sync` pulse.
- **Reset mid-operation:** all ticks drop asynchronously and `inc` reverts to INC_RST.

## Test plan
- **Default rate:** default parameters, no writes. Check `inc_q`=618475 after reset. Over 10^6 cycles, count `os_tick` = 36864±1 and `baud_tick` = 2304±1.
- **Exact divide:** ACC_W=8, OSR=4, write `inc`=64, pulse `sync`.
  - `os_tick` after edges 4, 8, 12, 16, …
  - `mid_tick` at cycle 8.
  - `baud_tick` at cycle 16.
  - `os_phase` sequence 1, 2, 3, 0.
- **Fractional jitter:** ACC_W=8, write `inc`=96. `os_tick` intervals are only 2 or 3 cycles. Exactly 3 ticks occur per 8 cycles, in the repeating interval pattern 3, 3, 2.
- **Sync mid-bit:** default `inc`, assert `sync` when `os_phase`=9. Same cycle: ticks are 0 and `os_phase` becomes 0. The next `baud_tick` arrives exactly 16 `os_tick` pulses later.
- **Increment write corner cases:**
  - Write `inc_din`=0: `inc_q` unchanged and ticks continue.
  - Write while `enable`=0: takes effect, and `acc` stays 0.
  - Write in the same cycle as `rst`: `inc_q`=INC_RST.
- **Async reset:** assert `rst` between clock edges while `os_tick`=1. All tick outputs go low and `os_phase`=0 before the next edge.
